// File: rtl/instr_trace_pkg.sv
// instr_trace_pkg: class codes, trace record layout and RV64 opcode constants
// shared by the commit-side trace classifier and its per-port decoder.
package instr_trace_pkg;

    typedef enum logic [3:0] {
        CLS_OTHER  = 4'd0,
        CLS_ALU    = 4'd1,
        CLS_MULDIV = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JUMP   = 4'd6,
        CLS_SYSTEM = 4'd7,
        CLS_FENCE  = 4'd8,
        CLS_AMO    = 4'd9,
        CLS_FP     = 4'd10,
        CLS_CORDIC = 4'd11
    } instr_class_e;

    // Record fields sized for the widest legal configuration; the top trims them.
    localparam int TRACE_PC_W   = 64;
    localparam int TRACE_PORT_W = 2;

    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [31:0]             instr;
        instr_class_e            cls;
        logic                    compressed;
        logic [TRACE_PORT_W-1:0] port;
    } trace_rec_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MADD     = 7'b1000011;
    localparam logic [6:0] OPC_MSUB     = 7'b1000111;
    localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_NMADD    = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [6:0] F7_CORDIC = 7'b0000100;

    localparam logic [2:0] F3_CORDIC_SIN = 3'b001;
    localparam logic [2:0] F3_CORDIC_COS = 3'b010;

    function automatic logic is_compressed(input logic [1:0] quad);
        return quad != 2'b11;
    endfunction

endpackage

// File: rtl/instr_trace_classifier_classify.sv
// instr_classify: combinational RV64IMAFDC + custom-0 CORDIC decoder,
// maps one raw encoding to a trace class code and a compressed flag.
module instr_classify
    import instr_trace_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  class_o,
    output logic        compressed_o
);

    instr_class_e cls32;
    instr_class_e cls16;
    logic [6:0]   opcode;
    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic [2:0]   c_funct3;
    logic [4:0]   c_rs1;
    logic [4:0]   c_rs2;

    assign opcode   = instr_i[6:0];
    assign funct7   = instr_i[31:25];
    assign funct3   = instr_i[14:12];
    assign c_funct3 = instr_i[15:13];
    assign c_rs1    = instr_i[11:7];
    assign c_rs2    = instr_i[6:2];

    always_comb begin
        cls32 = CLS_OTHER;
        case (opcode)
            OPC_LOAD, OPC_LOAD_FP:   cls32 = CLS_LOAD;
            OPC_STORE, OPC_STORE_FP: cls32 = CLS_STORE;
            OPC_OP_IMM, OPC_OP_IMM32,
            OPC_LUI, OPC_AUIPC:      cls32 = CLS_ALU;
            OPC_OP, OPC_OP32: begin
                if (funct7 == F7_MULDIV) begin
                    cls32 = CLS_MULDIV;
                end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    cls32 = CLS_ALU;
                end
            end
            OPC_BRANCH:              cls32 = CLS_BRANCH;
            OPC_JAL, OPC_JALR:       cls32 = CLS_JUMP;
            OPC_SYSTEM:              cls32 = CLS_SYSTEM;
            OPC_MISC_MEM:            cls32 = CLS_FENCE;
            OPC_AMO:                 cls32 = CLS_AMO;
            OPC_OP_FP, OPC_MADD, OPC_MSUB,
            OPC_NMSUB, OPC_NMADD:    cls32 = CLS_FP;
            OPC_CUSTOM0: begin
                if (funct7 == F7_CORDIC &&
                    (funct3 == F3_CORDIC_SIN || funct3 == F3_CORDIC_COS)) begin
                    cls32 = CLS_CORDIC;
                end
            end
            default: ;
        endcase
    end

    // Quadrant 1 funct3=001 is c.addiw on RV64, so it stays ALU.
    always_comb begin
        cls16 = CLS_ALU;
        case (instr_i[1:0])
            2'b00: begin
                case (c_funct3)
                    3'b000: if (instr_i[15:0] == 16'h0000) cls16 = CLS_OTHER;
                    3'b001, 3'b010, 3'b011: cls16 = CLS_LOAD;
                    3'b100:  cls16 = CLS_OTHER;
                    default: cls16 = CLS_STORE;
                endcase
            end
            2'b01: begin
                case (c_funct3)
                    3'b101:         cls16 = CLS_JUMP;
                    3'b110, 3'b111: cls16 = CLS_BRANCH;
                    default: ;
                endcase
            end
            default: begin
                case (c_funct3)
                    3'b001, 3'b010, 3'b011: cls16 = CLS_LOAD;
                    3'b101, 3'b110, 3'b111: cls16 = CLS_STORE;
                    3'b100: begin
                        if (instr_i[12] && c_rs1 == 5'd0 && c_rs2 == 5'd0) begin
                            cls16 = CLS_SYSTEM;
                        end else if (c_rs2 == 5'd0) begin
                            cls16 = CLS_JUMP;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    assign compressed_o = is_compressed(instr_i[1:0]);
    assign class_o      = compressed_o ? cls16 : cls32;

endmodule

// File: rtl/instr_trace_classifier.sv
// instr_trace_classifier: classifies retired instructions into a drop-on-full
// trace FIFO; INSTR_TRACE_CLASS_CNT_EN adds per-class retire counters.
module instr_trace_classifier
    import instr_trace_pkg::*;
#(
    parameter int NrCommitPorts = 2,
    parameter int XLEN          = 64,
    parameter int Depth         = 8,
    parameter int CntWidth      = 32,
    localparam int PortW        = (NrCommitPorts > 1) ? $clog2(NrCommitPorts) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NrCommitPorts-1:0]               commit_valid_i,
    input  logic [NrCommitPorts-1:0][XLEN-1:0]     commit_pc_i,
    input  logic [NrCommitPorts-1:0][31:0]         commit_instr_i,
    output logic                                   trace_valid_o,
    input  logic                                   trace_ready_i,
    output logic [XLEN-1:0]                        trace_pc_o,
    output logic [31:0]                            trace_instr_o,
    output logic [3:0]                             trace_class_o,
    output logic                                   trace_compressed_o,
    output logic [PortW-1:0]                       trace_port_o,
    output logic                                   overflow_o,
    output logic [CntWidth-1:0]                    drop_cnt_o,
    input  logic                                   cnt_clear_i,
    output logic [15:0][CntWidth-1:0]              class_cnt_o
);

    localparam int         AW     = $clog2(Depth);
    localparam logic [AW:0] DepthL = (AW+1)'(Depth);

    logic [NrCommitPorts-1:0][3:0] cls;
    logic [NrCommitPorts-1:0]      comp;

    for (genvar g = 0; g < NrCommitPorts; g++) begin : g_cls
        instr_classify u_classify (
            .instr_i      (commit_instr_i[g]),
            .class_o      (cls[g]),
            .compressed_o (comp[g])
        );
    end

    trace_rec_t          mem_q [Depth];
    trace_rec_t          mem_d [Depth];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic                pop;
    logic [AW:0]         free;
    logic [AW:0]         n_wr;
    logic [2:0]          n_drop;
    logic [CntWidth:0]   drop_sum;
    trace_rec_t          head;
    logic                unused_head;

    assign head          = mem_q[rd_ptr_q];
    assign trace_valid_o = count_q != '0;
    assign pop           = trace_valid_o & trace_ready_i;

    // Data outputs read as zero whenever no record is presented.
    assign trace_pc_o         = trace_valid_o ? head.pc[XLEN-1:0] : '0;
    assign trace_instr_o      = trace_valid_o ? head.instr : '0;
    assign trace_class_o      = trace_valid_o ? 4'(head.cls) : 4'd0;
    assign trace_compressed_o = trace_valid_o & head.compressed;
    assign trace_port_o       = trace_valid_o ? head.port[PortW-1:0] : '0;
    assign overflow_o         = overflow_q;
    assign drop_cnt_o         = drop_cnt_q;
    assign unused_head        = ^{head.pc, head.port};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + AW'(pop);
        free     = DepthL - count_q + (AW+1)'(pop);
        n_wr     = '0;
        n_drop   = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (commit_valid_i[p]) begin
                if (n_wr < free) begin
                    mem_d[wr_ptr_q + n_wr[AW-1:0]] = '{
                        pc:         TRACE_PC_W'(commit_pc_i[p]),
                        instr:      commit_instr_i[p],
                        cls:        instr_class_e'(cls[p]),
                        compressed: comp[p],
                        port:       TRACE_PORT_W'(p)
                    };
                    n_wr++;
                end else begin
                    n_drop++;
                end
            end
        end
        wr_ptr_d   = wr_ptr_q + n_wr[AW-1:0];
        count_d    = count_q - (AW+1)'(pop) + n_wr;
        drop_sum   = {1'b0, drop_cnt_q} + (CntWidth+1)'(n_drop);
        drop_cnt_d = drop_sum[CntWidth] ? '1 : drop_sum[CntWidth-1:0];
        overflow_d = overflow_q | (n_drop != '0);
        if (flush_i) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef INSTR_TRACE_CLASS_CNT_EN
    logic [15:0][CntWidth-1:0] class_cnt_q, class_cnt_d;
    logic [15:0][2:0]          cls_inc;
    logic [CntWidth:0]         cls_sum;

    always_comb begin
        cls_inc = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (commit_valid_i[p]) begin
                cls_inc[cls[p]] = cls_inc[cls[p]] + 3'd1;
            end
        end
        class_cnt_d = class_cnt_q;
        cls_sum     = '0;
        for (int k = 0; k < 16; k++) begin
            cls_sum        = {1'b0, class_cnt_q[k]} + (CntWidth+1)'(cls_inc[k]);
            class_cnt_d[k] = cls_sum[CntWidth] ? '1 : cls_sum[CntWidth-1:0];
        end
        if (cnt_clear_i) begin
            class_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            class_cnt_q <= '0;
        end else begin
            class_cnt_q <= class_cnt_d;
        end
    end

    assign class_cnt_o = class_cnt_q;
`else
    logic unused_cnt_clear;

    assign unused_cnt_clear = cnt_clear_i;
    assign class_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_instr_trace_classifier.sv
// tb_instr_trace_classifier: directed vectors with a scoreboard queue and a
// negedge monitor comparing every accepted head record.
module tb_instr_trace_classifier;

`ifdef INSTR_TRACE_CLASS_CNT_EN
    localparam int CntOn = 1;
`else
    localparam int CntOn = 0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [1:0]        commit_valid_i;
    logic [1:0][63:0]  commit_pc_i;
    logic [1:0][31:0]  commit_instr_i;
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [63:0]       trace_pc_o;
    logic [31:0]       trace_instr_o;
    logic [3:0]        trace_class_o;
    logic              trace_compressed_o;
    logic [0:0]        trace_port_o;
    logic              overflow_o;
    logic [31:0]       drop_cnt_o;
    logic              cnt_clear_i;
    logic [15:0][31:0] class_cnt_o;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [3:0]  cls;
        logic        comp;
        logic [0:0]  port;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] vin [22] = '{
        32'h02B50533, 32'h00B53023, 32'h00B50463, 32'h008000EF,
        32'h34029073, 32'h0FF0000F, 32'h00B5202F, 32'h02B57553,
        32'h0800200B, 32'h0800300B, 32'h000002B7, 32'h00000297,
        32'h00053007, 32'hFFFFFFFF, 32'h0000A001, 32'h0000C101,
        32'h00000001, 32'h00009002, 32'h0000E006, 32'h00008082,
        32'h0000952E, 32'h00004398
    };
    logic [3:0] vcls [22] = '{
        4'd2, 4'd4, 4'd5, 4'd6,
        4'd7, 4'd8, 4'd9, 4'd10,
        4'd11, 4'd0, 4'd1, 4'd1,
        4'd3, 4'd0, 4'd6, 4'd5,
        4'd1, 4'd7, 4'd4, 4'd6,
        4'd1, 4'd3
    };

    instr_trace_classifier dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .commit_valid_i     (commit_valid_i),
        .commit_pc_i        (commit_pc_i),
        .commit_instr_i     (commit_instr_i),
        .trace_valid_o      (trace_valid_o),
        .trace_ready_i      (trace_ready_i),
        .trace_pc_o         (trace_pc_o),
        .trace_instr_o      (trace_instr_o),
        .trace_class_o      (trace_class_o),
        .trace_compressed_o (trace_compressed_o),
        .trace_port_o       (trace_port_o),
        .overflow_o         (overflow_o),
        .drop_cnt_o         (drop_cnt_o),
        .cnt_clear_i        (cnt_clear_i),
        .class_cnt_o        (class_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (!rst_i && trace_valid_o && trace_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_rec: got pc=%0h instr=%0h, no record expected",
                         trace_pc_o, trace_instr_o);
            end else begin
                e = exp_q.pop_front();
                if (trace_pc_o !== e.pc || trace_instr_o !== e.instr ||
                    trace_class_o !== e.cls || trace_compressed_o !== e.comp ||
                    trace_port_o !== e.port) begin
                    errors++;
                    $display("FAIL rec: got pc=%0h instr=%0h cls=%0d c=%0b port=%0d, expected pc=%0h instr=%0h cls=%0d c=%0b port=%0d",
                             trace_pc_o, trace_instr_o, trace_class_o, trace_compressed_o,
                             trace_port_o, e.pc, e.instr, e.cls, e.comp, e.port);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        commit_valid_i = '0;
    endtask

    task automatic put(input int p, input logic [63:0] pc, input logic [31:0] ins,
                       input logic [3:0] cls, input bit enq);
        exp_t e;
        commit_valid_i[p] = 1'b1;
        commit_pc_i[p]    = pc;
        commit_instr_i[p] = ins;
        if (enq) begin
            e.pc    = pc;
            e.instr = ins;
            e.cls   = cls;
            e.comp  = (ins[1:0] != 2'b11);
            e.port  = 1'(p);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(trace_valid_o), 64'd0);
        chk({tag, "_pc"}, trace_pc_o, 64'd0);
        chk({tag, "_instr"}, 64'(trace_instr_o), 64'd0);
        chk({tag, "_class"}, 64'(trace_class_o), 64'd0);
        chk({tag, "_comp"}, 64'(trace_compressed_o), 64'd0);
        chk({tag, "_port"}, 64'(trace_port_o), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow_o), 64'd0);
        chk({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
        checks++;
        if (class_cnt_o !== '0) begin
            errors++;
            $display("FAIL %s_classcnt: got %0h expected 0", tag, class_cnt_o);
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        trace_ready_i  = 1'b0;
        cnt_clear_i    = 1'b0;
        commit_valid_i = '0;
        commit_pc_i    = '0;
        commit_instr_i = '0;
        repeat (2) step();
        rst_i = 1'b0;
        chk_reset("reset");

        trace_ready_i = 1'b1;
        put(0, 64'h1000, 32'h00000013, 4'd1, 1'b1);
        step();
        chk("lat_valid", 64'(trace_valid_o), 64'd1);
        step();

        put(0, 64'h2000, 32'h0800100B, 4'd11, 1'b1);
        put(1, 64'h2004, 32'h00004398, 4'd3, 1'b1);
        step();
        step();
        step();

        for (int i = 0; i < 11; i++) begin
            put(0, 64'h10000 + 64'(i * 8), vin[2*i], vcls[2*i], 1'b1);
            put(1, 64'h10004 + 64'(i * 8), vin[2*i+1], vcls[2*i+1], 1'b1);
            step();
            step();
        end
        wait_drain(20);

        trace_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            put(0, 64'h3000 + 64'(c * 8), 32'h00000013, 4'd1, c < 4);
            put(1, 64'h3004 + 64'(c * 8), 32'h00000013, 4'd1, c < 4);
            step();
        end
        chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_valid", 64'(trace_valid_o), 64'd1);

        trace_ready_i = 1'b1;
        put(0, 64'h4000, 32'h00B50463, 4'd5, 1'b1);
        put(1, 64'h4004, 32'h00B50463, 4'd5, 1'b0);
        step();
        chk("fullpop_drop", 64'(drop_cnt_o), 64'd3);
        chk("fullpop_ovf", 64'(overflow_o), 64'd1);
        wait_drain(20);
        chk("empty_valid", 64'(trace_valid_o), 64'd0);

        trace_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            put(0, 64'h6000 + 64'(c * 8), 32'h00053007, 4'd3, c < 4);
            put(1, 64'h6004 + 64'(c * 8), 32'h0000E006, 4'd4, c < 4);
            step();
        end
        flush_i = 1'b1;
        put(0, 64'h6100, 32'h00000013, 4'd1, 1'b0);
        put(1, 64'h6104, 32'h00000013, 4'd1, 1'b0);
        step();
        flush_i = 1'b0;
        exp_q.delete();
        chk("flush_valid", 64'(trace_valid_o), 64'd0);
        chk("flush_ovf", 64'(overflow_o), 64'd0);
        chk("flush_drop", 64'(drop_cnt_o), 64'd5);

        trace_ready_i = 1'b1;
        put(1, 64'h5000, 32'h0800200B, 4'd11, 1'b1);
        step();
        wait_drain(10);

        trace_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            put(0, 64'h8000 + 64'(c * 8), 32'h00000013, 4'd1, 1'b0);
            put(1, 64'h8004 + 64'(c * 8), 32'h00000013, 4'd1, 1'b0);
            step();
        end
        chk("pend_valid", 64'(trace_valid_o), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_reset("midrst");

        trace_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cnt_clear_i = (c == 2);
            put(0, 64'h9000 + 64'(c * 8), 32'h00B50463, 4'd5, 1'b1);
            put(1, 64'h9004 + 64'(c * 8), 32'h00B50463, 4'd5, 1'b1);
            step();
            if (c == 1) chk("cnt5_mid", 64'(class_cnt_o[5]), 64'(4 * CntOn));
        end
        cnt_clear_i = 1'b0;
        chk("cnt5_clr", 64'(class_cnt_o[5]), 64'd0);
        put(0, 64'h7000, 32'h00009002, 4'd7, 1'b1);
        step();
        chk("cnt7", 64'(class_cnt_o[7]), 64'(CntOn));
        wait_drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_trace_classifier.md
# instr_trace_classifier

Commit-side trace unit sitting beside the commit stage. Classifies up to NrCommitPorts retired instructions per cycle (RV64IMAFDC plus custom-0 CORDIC sin/cos) into a class code. Buffers one record per instruction in a multi-write/single-read FIFO that a trace sink drains over a valid/ready handshake. Never back-pressures commit: records are dropped on overflow and the drop is counted. Optional per-class retire counters.

## Interface
- NrCommitPorts, 2, commit ports sampled per cycle (1..4)
- XLEN, 64, PC width
- Depth, 8, FIFO entries; power of two, ≥ NrCommitPorts
- CntWidth, 32, width of drop and class counters
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  discard FIFO contents and clear overflow
- commit_valid_i  in  [NrCommitPorts]  instruction retires on port
- commit_pc_i  in  [NrCommitPorts][XLEN]  retired PC
- commit_instr_i  in  [NrCommitPorts][32]  raw encoding; compressed in [15:0]
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  sink accepts head
- trace_pc_o  out  XLEN  head PC
- trace_instr_o  out  32  head encoding
- trace_class_o  out  4  head class code
- trace_compressed_o  out  1  head is 16-bit
- trace_port_o  out  $clog2(NrCommitPorts) (min 1)  originating port
- overflow_o  out  1  sticky: ≥1 record dropped
- drop_cnt_o  out  CntWidth  saturating dropped-record count
- cnt_clear_i  in  1  zero class counters (macro only)
- class_cnt_o  out  [16][CntWidth]  per-class retire counts (macro only)

## Operation
- Class codes: 0 OTHER, 1 ALU, 2 MULDIV, 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP (jal/jalr/auipc excluded→ALU; lui, auipc→ALU), 7 SYSTEM (csr*, ecall, ebreak, xret, wfi, sfence), 8 FENCE (fence, fence.i), 9 AMO, 10 FP (loads/stores to FP regs stay LOAD/STORE), 11 CORDIC (custom-0 funct7=0000100, funct3 001 sin / 010 cos), 12–15 reserved.
- Compressed (instr[1:0]≠11): c.lw/ld/lwsp/ldsp/fld/fldsp/flw/flwsp→LOAD; c.sw/sd/swsp/sdsp/fsd/fsdsp/fsw/fswsp→STORE; c.beqz/bnez→BRANCH; c.j/jal/jr/jalr→JUMP; c.ebreak→SYSTEM (checked before c.jalr/c.add); all other legal→ALU; c.nop→ALU.
- Unmatched 32-bit encodings→OTHER.
- Enqueue: valid ports written in ascending port order into free slots; free = Depth − count + pop, where pop = trace_valid_o & trace_ready_i. Ports beyond free slots dropped; each drop increments drop_cnt_o (saturates at all-ones) and sets overflow_o.
- flush_i: next cycle count=0, overflow_o=0; same-cycle commits and pops discarded, not counted as drops; drop_cnt_o kept.
- Pointers wrap modulo Depth.

## Timing
- Reset: trace_valid_o=0, all trace_* data 0, overflow_o=0, drop_cnt_o=0, class_cnt_o all 0, pointers 0.
- Latency: commit in cycle t → record at head earliest in t+1.
- Head held stable while trace_valid_o & ~trace_ready_i.
- Full FIFO with pop in same cycle: one slot freed for that cycle's commits.
- Reset mid-operation: all state to reset values next cycle; flush_i and rst_i together behave as reset.

## Configuration
- INSTR_TRACE_CLASS_CNT_EN defined: 16 saturating counters; each cycle class k adds number of valid ports classified k (independent of FIFO drops/flush); cnt_clear_i wins over simultaneous increment (0 next cycle).
- Undefined: counters absent, class_cnt_o tied 0, cnt_clear_i ignored.

## Structure
- Shared package instr_trace_pkg: class-code enum, trace record struct {pc, instr, class, compressed, port}, encoding match constants.
- Sub-module instr_classify: purely combinational, one instance per commit port; instr → {class, compressed}.
- Top holds FIFO, drop logic, counters.

## Test plan
- Single addi 0x00000013 on port 0, ready=1 → next cycle trace_valid_o=1, class 1, compressed 0, port 0.
- Port0 sin (0x0800100B), port1 c.lw 0x4398 same cycle → two records in order: class 11 port 0, then class 3 compressed 1 port 1.
- Depth=8, ready=0, 5 cycles of 2 commits → 8 stored, drop_cnt_o=2, overflow_o=1; flush_i → trace_valid_o=0, overflow_o=0, drop_cnt_o=2.
- Full FIFO, ready=1, 2 commits → one enqueued, one dropped, count stays 8.
- Macro on: 3 cycles of beq on both ports, cnt_clear_i asserted in cycle 3 → class_cnt_o[5]=0 after; c.ebreak 0x9002 → class 7.
- rst_i asserted with 4 records pending → next cycle all outputs at reset values.
